cluster_boot_sequencer: RTL and testbench

//  Sequences cluster power-up and shut-down from SoC control-register commands, replacing direct

---
 rtl/cluster_boot_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cluster_boot_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_boot_sequencer.sv
// Cluster boot sequencer: turns one-cycle start/stop strobes from the SoC
// control registers into a timed reset / boot-mode / fetch-enable sequence
// for a compute cluster. The cluster control pins are a pure decode of the
// state register and the latched boot-mode bit, so they never glitch
// relative to the state code that software reads back.
module cluster_boot_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETUP_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned DRAIN_CYCLES  = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       sa_boot_i,
    output logic       cluster_ctrl_rstn_o,
    output logic       cluster_en_sa_boot_o,
    output logic       cluster_fetch_en_o,
    output logic       busy_o,
    output logic       running_o,
    output logic       done_o,
    output logic [2:0] state_o
);

    // The counter must hold the largest (N-1) load value.
    localparam int unsigned MAX_AB    = (HOLD_CYCLES > SETUP_CYCLES) ? HOLD_CYCLES : SETUP_CYCLES;
    localparam int unsigned MAX_CD    = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
    localparam int unsigned MAX_ALL   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETUP_LOAD  = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD  = CNT_WIDTH'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    // State codes are visible to software through state_o; keep them stable.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_HOLD = 3'd1;
    localparam logic [2:0] ST_SETUP    = 3'd2;
    localparam logic [2:0] ST_RELEASE  = 3'd3;
    localparam logic [2:0] ST_RUNNING  = 3'd4;
    localparam logic [2:0] ST_DRAIN    = 3'd5;

    logic [2:0]           state_reg,   state_next;
    logic [CNT_WIDTH-1:0] cnt_reg,     cnt_next;
    logic                 sa_boot_reg, sa_boot_next;
    logic                 done_reg,    done_next;

    // Next-state logic: each timed state loads N-1 on entry and leaves at zero.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        sa_boot_next = sa_boot_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A simultaneous stop cancels the start.
                if (start_i && !stop_i) begin
                    state_next   = ST_RST_HOLD;
                    cnt_next     = HOLD_LOAD;
                    sa_boot_next = sa_boot_i;
                end
            end
            ST_RST_HOLD: begin
                if (stop_i) begin
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end else if (cnt_reg == CNT_ZERO) begin
                    state_next = ST_SETUP;
                    cnt_next   = SETUP_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_SETUP: begin
                if (stop_i) begin
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end else if (cnt_reg == CNT_ZERO) begin
                    state_next = ST_RELEASE;
                    cnt_next   = SETTLE_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (stop_i) begin
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end else if (cnt_reg == CNT_ZERO) begin
                    state_next = ST_RUNNING;
                    cnt_next   = CNT_ZERO;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_RUNNING: begin
                if (stop_i) begin
                    state_next = ST_DRAIN;
                    cnt_next   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // Drain always runs to completion; late stops are ignored.
                if (cnt_reg == CNT_ZERO) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, boot-mode latch and done pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= CNT_ZERO;
            sa_boot_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            sa_boot_reg <= sa_boot_next;
            done_reg    <= done_next;
        end
    end

    // Cluster control and status decode from the registered state.
    always_comb begin
        cluster_ctrl_rstn_o  = 1'b0;
        cluster_en_sa_boot_o = 1'b0;
        cluster_fetch_en_o   = 1'b0;
        busy_o               = 1'b0;
        running_o            = 1'b0;
        case (state_reg)
            ST_RST_HOLD: begin
                busy_o = 1'b1;
            end
            ST_SETUP: begin
                cluster_en_sa_boot_o = sa_boot_reg;
                busy_o               = 1'b1;
            end
            ST_RELEASE: begin
                cluster_ctrl_rstn_o  = 1'b1;
                cluster_en_sa_boot_o = sa_boot_reg;
                busy_o               = 1'b1;
            end
            ST_RUNNING: begin
                cluster_ctrl_rstn_o  = 1'b1;
                cluster_en_sa_boot_o = sa_boot_reg;
                cluster_fetch_en_o   = 1'b1;
                running_o            = 1'b1;
            end
            ST_DRAIN: begin
                cluster_ctrl_rstn_o  = 1'b1;
                cluster_en_sa_boot_o = sa_boot_reg;
                busy_o               = 1'b1;
            end
            default: begin
                cluster_ctrl_rstn_o = 1'b0;
            end
        endcase
    end

    assign done_o  = done_reg;
    assign state_o = state_reg;

endmodule

// File: tb/tb_cluster_boot_sequencer.sv
// Bench for cluster_boot_sequencer. Stimulus pushes the expected output
// changes (cycle number plus full output vector) into a queue per DUT; a
// monitor per DUT pops one entry every time the DUT outputs change.
module tb_cluster_boot_sequencer;

    logic clk = 1'b0;
    logic rst_i;
    logic start_a, stop_a, sa_a;
    logic start_b, stop_b, sa_b;

    logic       rstn_a, sab_a, fetch_a, busy_a, run_a, done_a;
    logic [2:0] st_a;
    logic       rstn_b, sab_b, fetch_b, busy_b, run_b, done_b;
    logic [2:0] st_b;

    always #5 clk = ~clk;

    // Default timing.
    cluster_boot_sequencer dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_a), .stop_i(stop_a), .sa_boot_i(sa_a),
        .cluster_ctrl_rstn_o(rstn_a), .cluster_en_sa_boot_o(sab_a), .cluster_fetch_en_o(fetch_a),
        .busy_o(busy_a), .running_o(run_a), .done_o(done_a), .state_o(st_a)
    );

    // Minimum timing, every phase one cycle.
    cluster_boot_sequencer #(
        .HOLD_CYCLES(1), .SETUP_CYCLES(1), .SETTLE_CYCLES(1), .DRAIN_CYCLES(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_b), .stop_i(stop_b), .sa_boot_i(sa_b),
        .cluster_ctrl_rstn_o(rstn_b), .cluster_en_sa_boot_o(sab_b), .cluster_fetch_en_o(fetch_b),
        .busy_o(busy_b), .running_o(run_b), .done_o(done_b), .state_o(st_b)
    );

    typedef struct {
        int         cyc;
        logic [8:0] v;
    } ev_t;

    ev_t exp_q0[$];
    ev_t exp_q1[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_en = 0;
    bit  force0 = 0;
    bit  force1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected output vector {state, rstn, sa_boot, fetch_en, busy, running, done}.
    function automatic logic [8:0] exp_vec(input logic [2:0] st, input logic sa, input logic dn);
        logic rstn, sab, fe, bz, rn;
        rstn = (st == 3'd3) || (st == 3'd4) || (st == 3'd5);
        sab  = (st >= 3'd2 && st <= 3'd5) ? sa : 1'b0;
        fe   = (st == 3'd4);
        bz   = (st == 3'd1) || (st == 3'd2) || (st == 3'd3) || (st == 3'd5);
        rn   = (st == 3'd4);
        return {st, rstn, sab, fe, bz, rn, dn};
    endfunction

    function automatic void push0(input int c, input logic [2:0] st, input logic sa, input logic dn);
        ev_t e;
        e.cyc = c;
        e.v   = exp_vec(st, sa, dn);
        exp_q0.push_back(e);
    endfunction

    function automatic void push1(input int c, input logic [2:0] st, input logic sa, input logic dn);
        ev_t e;
        e.cyc = c;
        e.v   = exp_vec(st, sa, dn);
        exp_q1.push_back(e);
    endfunction

    // Normal boot from a start issued in cycle t.
    function automatic void push_boot0(input int t, input logic sa);
        push0(t + 1,  3'd1, sa, 1'b0);
        push0(t + 17, 3'd2, sa, 1'b0);
        push0(t + 21, 3'd3, sa, 1'b0);
        push0(t + 29, 3'd4, sa, 1'b1);
        push0(t + 30, 3'd4, sa, 1'b0);
    endfunction

    // Monitor for the default-timing DUT.
    logic [8:0] prev0, got0;
    always @(negedge clk) begin
        if (mon_en) begin
            got0 = {st_a, rstn_a, sab_a, fetch_a, busy_a, run_a, done_a};
            if (force0 || got0 !== prev0) begin
                force0 = 0;
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL dut0_unexpected cyc=%0d got=%b", cyc, got0);
                end else begin
                    ev_t e;
                    e = exp_q0.pop_front();
                    if (e.cyc != cyc || e.v !== got0) begin
                        errors++;
                        $display("FAIL dut0_event cyc=%0d got=%b want cyc=%0d vec=%b", cyc, got0, e.cyc, e.v);
                    end
                end
            end
            prev0 = got0;
        end
    end

    // Monitor for the minimum-timing DUT.
    logic [8:0] prev1, got1;
    always @(negedge clk) begin
        if (mon_en) begin
            got1 = {st_b, rstn_b, sab_b, fetch_b, busy_b, run_b, done_b};
            if (force1 || got1 !== prev1) begin
                force1 = 0;
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL dut1_unexpected cyc=%0d got=%b", cyc, got1);
                end else begin
                    ev_t e;
                    e = exp_q1.pop_front();
                    if (e.cyc != cyc || e.v !== got1) begin
                        errors++;
                        $display("FAIL dut1_event cyc=%0d got=%b want cyc=%0d vec=%b", cyc, got1, e.cyc, e.v);
                    end
                end
            end
            prev1 = got1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic drive0(input logic s, input logic p, input logic b);
        start_a = s; stop_a = p; sa_a = b;
        step();
        start_a = 1'b0; stop_a = 1'b0; sa_a = 1'b0;
    endtask

    task automatic drive1(input logic s, input logic p, input logic b);
        start_b = s; stop_b = p; sa_b = b;
        step();
        start_b = 1'b0; stop_b = 1'b0; sa_b = 1'b0;
    endtask

    initial begin
        int t;
        rst_i = 1'b1;
        start_a = 1'b0; stop_a = 1'b0; sa_a = 1'b0;
        start_b = 1'b0; stop_b = 1'b0; sa_b = 1'b0;
        wait_cycles(3);

        // Reset values on both DUTs.
        push0(cyc, 3'd0, 1'b0, 1'b0);
        push1(cyc, 3'd0, 1'b0, 1'b0);
        force0 = 1; force1 = 1; mon_en = 1;
        rst_i = 1'b0;
        wait_cycles(2);

        // Boot with stand-alone mode; start while RUNNING is ignored.
        t = cyc;
        push_boot0(t, 1'b1);
        drive0(1'b1, 1'b0, 1'b1);
        wait_cycles(34);
        drive0(1'b1, 1'b0, 1'b0);
        wait_cycles(2);

        // Stop from RUNNING; stop and start during DRAIN are ignored.
        t = cyc;
        push0(t + 1,  3'd5, 1'b1, 1'b0);
        push0(t + 33, 3'd0, 1'b0, 1'b0);
        drive0(1'b0, 1'b1, 1'b0);
        wait_cycles(9);
        drive0(1'b0, 1'b1, 1'b0);
        drive0(1'b1, 1'b0, 1'b1);
        wait_cycles(30);

        // Stop alone in IDLE does nothing.
        drive0(1'b0, 1'b1, 1'b0);
        wait_cycles(2);

        // Abort in SETUP (stop 18 cycles after start).
        t = cyc;
        push0(t + 1,  3'd1, 1'b0, 1'b0);
        push0(t + 17, 3'd2, 1'b0, 1'b0);
        push0(t + 19, 3'd0, 1'b0, 1'b0);
        drive0(1'b1, 1'b0, 1'b0);
        wait_cycles(17);
        drive0(1'b0, 1'b1, 1'b0);
        wait_cycles(4);

        // Abort in RST_HOLD.
        t = cyc;
        push0(t + 1, 3'd1, 1'b0, 1'b0);
        push0(t + 6, 3'd0, 1'b0, 1'b0);
        drive0(1'b1, 1'b0, 1'b1);
        wait_cycles(4);
        drive0(1'b0, 1'b1, 1'b0);
        wait_cycles(3);

        // Abort in RELEASE: reset falls again, no fetch enable or done.
        t = cyc;
        push0(t + 1,  3'd1, 1'b1, 1'b0);
        push0(t + 17, 3'd2, 1'b1, 1'b0);
        push0(t + 21, 3'd3, 1'b1, 1'b0);
        push0(t + 26, 3'd0, 1'b0, 1'b0);
        drive0(1'b1, 1'b0, 1'b1);
        wait_cycles(24);
        drive0(1'b0, 1'b1, 1'b0);
        wait_cycles(3);

        // Start and stop together in IDLE: both ignored.
        drive0(1'b1, 1'b1, 1'b1);
        wait_cycles(2);

        // Start during RELEASE is ignored; sa_boot stays as latched (0).
        t = cyc;
        push_boot0(t, 1'b0);
        drive0(1'b1, 1'b0, 1'b0);
        wait_cycles(21);
        drive0(1'b1, 1'b0, 1'b1);
        wait_cycles(12);

        // Start and stop together in RUNNING: stop wins.
        t = cyc;
        push0(t + 1,  3'd5, 1'b0, 1'b0);
        push0(t + 33, 3'd0, 1'b0, 1'b0);
        drive0(1'b1, 1'b1, 1'b0);
        wait_cycles(36);

        // Synchronous reset while RUNNING, then a clean reboot.
        t = cyc;
        push_boot0(t, 1'b1);
        drive0(1'b1, 1'b0, 1'b1);
        wait_cycles(34);
        t = cyc;
        push0(t + 1, 3'd0, 1'b0, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        wait_cycles(2);
        t = cyc;
        push_boot0(t, 1'b0);
        drive0(1'b1, 1'b0, 1'b0);
        wait_cycles(34);
        t = cyc;
        push0(t + 1,  3'd5, 1'b0, 1'b0);
        push0(t + 33, 3'd0, 1'b0, 1'b0);
        drive0(1'b0, 1'b1, 1'b0);
        wait_cycles(36);

        // Minimum timing: rstn at +3, fetch at +4, stop at +10 -> IDLE at +12.
        t = cyc;
        push1(t + 1, 3'd1, 1'b1, 1'b0);
        push1(t + 2, 3'd2, 1'b1, 1'b0);
        push1(t + 3, 3'd3, 1'b1, 1'b0);
        push1(t + 4, 3'd4, 1'b1, 1'b1);
        push1(t + 5, 3'd4, 1'b1, 1'b0);
        push1(t + 11, 3'd5, 1'b1, 1'b0);
        push1(t + 12, 3'd0, 1'b0, 1'b0);
        drive1(1'b1, 1'b0, 1'b1);
        wait_cycles(9);
        drive1(1'b0, 1'b1, 1'b0);
        wait_cycles(6);

        // Every expected event must have been seen.
        checks++;
        if (exp_q0.size() != 0) begin
            errors++;
            $display("FAIL dut0_missing got=%0d pending want=0", exp_q0.size());
        end
        checks++;
        if (exp_q1.size() != 0) begin
            errors++;
            $display("FAIL dut1_missing got=%0d pending want=0", exp_q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
